// File: rtl/overlap_feed.sv
// Transposed-convolution feed: multiplies each accepted pixel by every row of a
// preloaded KxK kernel and streams K product row vectors to the overlap-add stage.
module overlap_feed #(
  parameter int PIX_WIDTH       = 8,
  parameter int SIZE_OF_WEIGHT  = 5,
  parameter int SIZE_OF_FEATURE = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [31:0]                         i_param_cfg_feature,
  input  logic                                start_i,
  input  logic                                w_valid_i,
  input  logic [SIZE_OF_WEIGHT*PIX_WIDTH-1:0] w_row_i,
  output logic                                w_ready_o,
  input  logic                                valid_i,
  input  logic [PIX_WIDTH-1:0]                pixel_i,
  output logic                                ready_o,
  output logic [SIZE_OF_WEIGHT*PIX_WIDTH-1:0] buffer_o,
  output logic                                valid_o,
  output logic                                wr_en_o,
  output logic [5:0]                          row_idx_o,
  output logic                                frame_done_o,
  output logic                                busy_o
);

  localparam int K  = SIZE_OF_WEIGHT;
  localparam int PW = PIX_WIDTH;
  localparam int VW = K * PW;
  localparam int RW = (K > 1) ? $clog2(K) : 1;
  localparam int CW = 12;
  localparam logic [RW-1:0] R_LAST = RW'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_W = 2'd1,
    S_RUN    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   beat_q, beat_d;
  logic [CW-1:0]   total_q, total_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic            held_q, held_d;
  logic [RW-1:0]   r_q, r_d;
  logic [VW-1:0]   w_q [K];
  logic [VW-1:0]   w_d [K];
  logic [VW-1:0]   buffer_q, buffer_d;
  logic            valid_q, valid_d;
  logic [5:0]      row_q, row_d;
  logic            done_q, done_d;

  logic            accept_s;
  logic            w_ready_s;
  logic            ready_s;
  logic            busy_s;
  logic            r_last_s;
  logic            beat_last_s;
  logic [5:0]      f_sel_s;
  logic [VW-1:0]   w_sel_s;
  logic [VW-1:0]   prod_vec_s;
  logic [2*PW-1:0] prod_s [K];
  logic            unused_cfg_s;

  assign unused_cfg_s = ^i_param_cfg_feature[31:6];
  assign r_last_s     = (r_q == R_LAST);
  assign beat_last_s  = (beat_q == R_LAST);
  assign accept_s     = valid_i && ready_s;
  assign f_sel_s      = (i_param_cfg_feature[5:0] == 6'd0) ? 6'(SIZE_OF_FEATURE)
                                                         : i_param_cfg_feature[5:0];

  // state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; RUN leaves on the cycle the final vector is presented
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD_W;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_W: begin
        if (w_valid_i && beat_last_s) begin
          state_d = S_RUN;
        end else begin
          state_d = S_LOAD_W;
        end
      end
      S_RUN: begin
        if (done_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state-decoded handshake outputs
  always_comb begin
    w_ready_s = (state_q == S_LOAD_W);
    busy_s    = (state_q != S_IDLE);
    ready_s   = (state_q == S_RUN) && (!held_q || r_last_s) && (cnt_q < total_q);
  end

  // one full-width product per kernel column, upper half kept
  always_comb begin
    w_sel_s    = w_q[r_q];
    prod_vec_s = '0;
    for (int j = 0; j < K; j++) begin
      prod_s[j] = {{PW{1'b0}}, pix_q} * {{PW{1'b0}}, w_sel_s[j*PW +: PW]};
      prod_vec_s[j*PW +: PW] = prod_s[j][2*PW-1:PW];
    end
  end

  // frame setup, weight load and pixel hold sequencing
  always_comb begin
    beat_d  = beat_q;
    total_d = total_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;
    held_d  = held_q;
    r_d     = r_q;
    w_d     = w_q;

    if ((state_q == S_IDLE) && start_i) begin
      beat_d  = '0;
      cnt_d   = '0;
      total_d = CW'(f_sel_s) * CW'(f_sel_s);
    end else if ((state_q == S_LOAD_W) && w_valid_i) begin
      w_d[beat_q] = w_row_i;
      beat_d      = beat_last_s ? '0 : beat_q + RW'(1);
    end else begin
      beat_d = beat_q;
    end

    if (accept_s) begin
      pix_d  = pixel_i;
      held_d = 1'b1;
      r_d    = '0;
      cnt_d  = cnt_q + CW'(1);
    end else if (held_q) begin
      if (r_last_s) begin
        held_d = 1'b0;
        r_d    = '0;
      end else begin
        r_d = r_q + RW'(1);
      end
    end else begin
      r_d = r_q;
    end
  end

  // output vector formation
  always_comb begin
    buffer_d = buffer_q;
    row_d    = row_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    if (held_q) begin
      buffer_d = prod_vec_s;
      row_d    = 6'(r_q);
      valid_d  = 1'b1;
      done_d   = r_last_s && (cnt_q == total_q);
    end else begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  // datapath and output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      beat_q   <= '0;
      total_q  <= '0;
      cnt_q    <= '0;
      pix_q    <= '0;
      held_q   <= 1'b0;
      r_q      <= '0;
      buffer_q <= '0;
      valid_q  <= 1'b0;
      row_q    <= 6'd0;
      done_q   <= 1'b0;
      for (int i = 0; i < K; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      beat_q   <= beat_d;
      total_q  <= total_d;
      cnt_q    <= cnt_d;
      pix_q    <= pix_d;
      held_q   <= held_d;
      r_q      <= r_d;
      buffer_q <= buffer_d;
      valid_q  <= valid_d;
      row_q    <= row_d;
      done_q   <= done_d;
      for (int i = 0; i < K; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  assign w_ready_o    = w_ready_s;
  assign ready_o      = ready_s;
  assign busy_o       = busy_s;
  assign buffer_o     = buffer_q;
  assign valid_o      = valid_q;
  assign wr_en_o      = valid_q;
  assign row_idx_o    = row_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_overlap_feed.sv
// Directed bench for overlap_feed: a scoreboard of expected row vectors is filled
// on every pixel handshake and drained by an output monitor.
module tb_overlap_feed;

  localparam int K  = 5;
  localparam int PW = 8;
  localparam int VW = K * PW;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [31:0]   i_param_cfg_feature;
  logic          start_i;
  logic          w_valid_i;
  logic [VW-1:0] w_row_i;
  logic          w_ready_o;
  logic          valid_i;
  logic [PW-1:0] pixel_i;
  logic          ready_o;
  logic [VW-1:0] buffer_o;
  logic          valid_o;
  logic          wr_en_o;
  logic [5:0]    row_idx_o;
  logic          frame_done_o;
  logic          busy_o;

  overlap_feed #(.PIX_WIDTH(PW), .SIZE_OF_WEIGHT(K), .SIZE_OF_FEATURE(2)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .i_param_cfg_feature (i_param_cfg_feature),
    .start_i             (start_i),
    .w_valid_i           (w_valid_i),
    .w_row_i             (w_row_i),
    .w_ready_o           (w_ready_o),
    .valid_i             (valid_i),
    .pixel_i             (pixel_i),
    .ready_o             (ready_o),
    .buffer_o            (buffer_o),
    .valid_o             (valid_o),
    .wr_en_o             (wr_en_o),
    .row_idx_o           (row_idx_o),
    .frame_done_o        (frame_done_o),
    .busy_o              (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [VW-1:0] vec;
    logic [5:0]    row;
    logic          done;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic [PW-1:0] tb_w [K][K];
  logic [PW-1:0] pix_list[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_total = 0;
  int tb_pix_cnt = 0;
  int vec_seen = 0;
  int done_seen = 0;
  bit done_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] wrow(input int r);
    logic [VW-1:0] v;
    for (int j = 0; j < K; j++) v[j*PW +: PW] = tb_w[r][j];
    return v;
  endfunction

  function automatic logic [VW-1:0] exp_vec(input int r, input logic [PW-1:0] p);
    logic [VW-1:0] v;
    logic [15:0]   prod;
    for (int j = 0; j < K; j++) begin
      prod = 16'(p) * 16'(tb_w[r][j]);
      v[j*PW +: PW] = prod[15:8];
    end
    return v;
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  // output monitor and handshake scoreboard
  always @(negedge clk_i) begin
    exp_t e;
    if (done_prev) chk("busy_fall_after_done", busy_o, 1'b0);
    if (valid_o) begin
      chk("wr_en_eq_valid", wr_en_o, 1'b1);
      if (sb.size() == 0) begin
        chk("unexpected_vector", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("buffer", buffer_o, e.vec);
        chk("row_idx", row_idx_o, e.row);
        chk("frame_done", frame_done_o, e.done);
        chk("latency_cycle", cyc, e.cyc);
        vec_seen++;
        if (frame_done_o) begin
          done_seen++;
          chk("busy_at_done", busy_o, 1'b1);
        end
      end
    end else begin
      chk("done_without_valid", frame_done_o, 1'b0);
    end
    done_prev = valid_o && frame_done_o;
    if (valid_i && ready_o) begin
      tb_pix_cnt++;
      for (int r = 0; r < K; r++) begin
        e.vec  = exp_vec(r, pixel_i);
        e.row  = 6'(r);
        e.done = (r == K - 1) && (tb_pix_cnt == exp_total);
        e.cyc  = cyc + 2 + r;
        sb.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_w_const(input logic [PW-1:0] v);
    for (int r = 0; r < K; r++)
      for (int j = 0; j < K; j++) tb_w[r][j] = v;
  endtask

  task automatic set_w_rand();
    for (int r = 0; r < K; r++)
      for (int j = 0; j < K; j++) tb_w[r][j] = 8'($urandom_range(0, 255));
  endtask

  task automatic start_frame(input logic [5:0] f);
    int fe;
    fe = (f == 6'd0) ? 2 : int'(f);
    exp_total  = fe * fe;
    tb_pix_cnt = 0;
    i_param_cfg_feature = {26'd0, f};
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    i_param_cfg_feature = 32'hFFFF_FFFF;
    chk("w_ready_after_start", w_ready_o, 1'b1);
    chk("busy_after_start", busy_o, 1'b1);
  endtask

  task automatic load_w();
    for (int r = 0; r < K; r++) begin
      w_valid_i = 1'b1;
      w_row_i   = wrow(r);
      step();
    end
    w_valid_i = 1'b0;
    w_row_i   = '0;
    chk("ready_after_load", ready_o, 1'b1);
    chk("w_ready_after_load", w_ready_o, 1'b0);
  endtask

  task automatic feed(input bit toggle);
    int idx = 0;
    int budget = 0;
    int since = 100;
    bit ph = 1'b1;
    bit acc;
    while (idx < pix_list.size() && budget < 500) begin
      valid_i = toggle ? ph : 1'b1;
      pixel_i = pix_list[idx];
      if (since >= 1 && since <= 4) chk("ready_low_mid_pixel", ready_o, 1'b0);
      if (since == 5) chk("ready_at_last_row", ready_o, 1'b1);
      acc = valid_i && ready_o;
      step();
      budget++;
      ph = ~ph;
      since++;
      if (acc) begin
        idx++;
        since = 1;
      end
    end
    valid_i = 1'b0;
    if (budget >= 500) chk("feed_timeout", 1'b1, 1'b0);
  endtask

  task automatic drain();
    int b = 0;
    while (sb.size() > 0 && b < 100) begin
      step();
      b++;
    end
    if (b >= 100) chk("drain_timeout", 1'b1, 1'b0);
    step();
    step();
    chk("idle_after_frame", busy_o, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, valid_o, 1'b0);
    chk({tag, "_wr_en"}, wr_en_o, 1'b0);
    chk({tag, "_buffer"}, buffer_o, '0);
    chk({tag, "_row"}, row_idx_o, 6'd0);
    chk({tag, "_done"}, frame_done_o, 1'b0);
    chk({tag, "_w_ready"}, w_ready_o, 1'b0);
    chk({tag, "_ready"}, ready_o, 1'b0);
    chk({tag, "_busy"}, busy_o, 1'b0);
  endtask

  initial begin
    int v0, d0;
    rst_i = 1'b0;
    i_param_cfg_feature = 32'd0;
    start_i = 1'b0;
    w_valid_i = 1'b0;
    w_row_i = '0;
    valid_i = 1'b0;
    pixel_i = '0;
    repeat (3) step();
    chk_all_zero("reset");
    rst_i = 1'b1;
    step();

    // constant 0x80 kernel, F=2, four pixels held valid
    set_w_const(8'h80);
    v0 = vec_seen; d0 = done_seen;
    start_frame(6'd2);
    load_w();
    pix_list = '{8'hFF, 8'h40, 8'h00, 8'h01};
    feed(1'b0);
    drain();
    chk("frameA_vectors", vec_seen - v0, 20);
    chk("frameA_done_pulses", done_seen - d0, 1);

    // full-scale kernel; valid_i during LOAD_W must not be accepted
    set_w_const(8'hFF);
    start_frame(6'd1);
    valid_i = 1'b1;
    pixel_i = 8'h55;
    chk("ready_low_in_load", ready_o, 1'b0);
    step();
    chk("ready_low_in_load2", ready_o, 1'b0);
    valid_i = 1'b0;
    load_w();
    pix_list = '{8'hFF};
    feed(1'b0);
    drain();
    start_frame(6'd1);
    load_w();
    pix_list = '{8'h01};
    feed(1'b0);
    drain();

    // random kernel, F=3, valid_i toggling every other cycle
    set_w_rand();
    v0 = vec_seen;
    start_frame(6'd3);
    load_w();
    pix_list.delete();
    for (int i = 0; i < 9; i++) pix_list.push_back(8'($urandom_range(0, 255)));
    feed(1'b1);
    drain();
    chk("frameC_vectors", vec_seen - v0, 45);

    // config 0 selects the default side; start_i in RUN is ignored
    set_w_rand();
    v0 = vec_seen;
    start_frame(6'd0);
    load_w();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("start_ignored_in_run", w_ready_o, 1'b0);
    chk("ready_still_high_in_run", ready_o, 1'b1);
    pix_list = '{8'h12, 8'hA5, 8'h7E, 8'hC3};
    feed(1'b0);
    drain();
    chk("frameD_vectors", vec_seen - v0, 20);

    // asynchronous reset while the pixel sits at row 2
    set_w_const(8'h10);
    start_frame(6'd2);
    load_w();
    valid_i = 1'b1;
    pixel_i = 8'h33;
    step();
    valid_i = 1'b0;
    step();
    step();
    #1;
    rst_i = 1'b0;
    #1;
    sb.delete();
    done_prev = 1'b0;
    chk_all_zero("async_reset");
    step();
    chk_all_zero("reset_next_cycle");
    #2;
    rst_i = 1'b1;
    step();
    set_w_const(8'h80);
    v0 = vec_seen;
    start_frame(6'd1);
    load_w();
    pix_list = '{8'hFF};
    feed(1'b0);
    drain();
    chk("post_reset_vectors", vec_seen - v0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
